video_pattern_src: RTL and testbench

Synthesizable video stream source that emits the `di/de/hs/vs` pixel protocol consumed by the scaler (`scaler_h`) and checked by `monitor`.
- Generates frames of programmable width, height, pixel gap, line blanking and frame blanking, carrying a selectable test pattern.
- Sits in front of the scaler in hardware bring-up builds and in benches, replacing file-driven stimulus.

---
 rtl/video_pattern_src_pkg.sv | 19 +
 rtl/video_pattern_calc.sv | 32 +++
 rtl/video_pattern_src.sv | 155 +++++++++++++++
 tb/tb_video_pattern_src.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pattern_src_pkg.sv
`default_nettype none
// video_pattern_src_pkg: FSM state encoding and test-pattern codes shared by the pattern source.
// Revision 1.0
package video_pattern_src_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LINE   = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } state_t;

  localparam logic [1:0] PAT_X     = 2'd0;
  localparam logic [1:0] PAT_Y     = 2'd1;
  localparam logic [1:0] PAT_SUM   = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

endpackage
`default_nettype wire

// File: rtl/video_pattern_calc.sv
`default_nettype none
// video_pattern_calc: combinational map from pixel coordinates and pattern code to pixel value.
// Revision 1.0
module video_pattern_calc
  import video_pattern_src_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic [PIXEL_WIDTH-1:0] x,
  input  logic [PIXEL_WIDTH-1:0] y,
  input  logic [1:0]             pattern,
  output logic [PIXEL_WIDTH-1:0] pixel
);

  // Only the low coordinate bits reach this block; the truncated sum is all that is needed.
  logic [PIXEL_WIDTH-1:0] sum;

  assign sum = x + y;

  always_comb begin
    pixel = '0;
    case (pattern)
      PAT_X:     pixel = x;
      PAT_Y:     pixel = y;
      PAT_SUM:   pixel = sum;
      PAT_CHECK: pixel = (x[3] ^ y[3]) ? '1 : '0;
      default:   pixel = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/video_pattern_src.sv
`default_nettype none
// video_pattern_src: programmable di/de/hs/vs frame generator with selectable test pattern.
// Revision 1.0
module video_pattern_src
  import video_pattern_src_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reg_en,
  input  logic [CNT_WIDTH-1:0]   reg_width,
  input  logic [CNT_WIDTH-1:0]   reg_height,
  input  logic [3:0]             reg_de_gap,
  input  logic [CNT_WIDTH-1:0]   reg_hblank,
  input  logic [CNT_WIDTH-1:0]   reg_vblank,
  input  logic [1:0]             reg_pattern,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   busy_o,
  output logic                   frame_done_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state;
  logic [CNT_WIDTH-1:0] x;
  logic [CNT_WIDTH-1:0] y;
  logic [CNT_WIDTH-1:0] tmr;

  logic [CNT_WIDTH-1:0] sh_width;
  logic [CNT_WIDTH-1:0] sh_height;
  logic [3:0]           sh_de_gap;
  logic [CNT_WIDTH-1:0] sh_hblank;
  logic [CNT_WIDTH-1:0] sh_vblank;
  logic [1:0]           sh_pattern;

  logic                   start_ok;
  logic                   load_shadow;
  logic                   in_frame;
  logic [CNT_WIDTH-1:0]   gap_load;
  logic [CNT_WIDTH-1:0]   hblank_load;
  logic [CNT_WIDTH-1:0]   vblank_load;
  logic [PIXEL_WIDTH-1:0] pixel;

  assign start_ok    = reg_en && (reg_width != '0) && (reg_height != '0);
  assign load_shadow = start_ok && ((state == IDLE) || ((state == VBLANK) && (tmr == '0)));
  assign in_frame    = (state == LINE) || (state == HBLANK);

  // The shared timer counts down to zero, so a blanking length of N loads N-1.
  assign gap_load    = {{(CNT_WIDTH-4){1'b0}}, sh_de_gap};
  assign hblank_load = (sh_hblank == '0) ? '0 : sh_hblank - CNT_ONE;
  assign vblank_load = (sh_vblank == '0) ? '0 : sh_vblank - CNT_ONE;

  video_pattern_calc #(
    .PIXEL_WIDTH (PIXEL_WIDTH)
  ) u_calc (
    .x       (x[PIXEL_WIDTH-1:0]),
    .y       (y[PIXEL_WIDTH-1:0]),
    .pattern (sh_pattern),
    .pixel   (pixel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      tmr          <= '0;
      sh_width     <= '0;
      sh_height    <= '0;
      sh_de_gap    <= '0;
      sh_hblank    <= '0;
      sh_vblank    <= '0;
      sh_pattern   <= '0;
      do_o         <= '0;
      de_o         <= 1'b0;
      hs_o         <= 1'b1;
      vs_o         <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      // Outputs are decoded from the current state, so the whole stream trails the FSM by one cycle.
      de_o         <= 1'b0;
      hs_o         <= (state != LINE);
      vs_o         <= in_frame;
      busy_o       <= (state != IDLE);
      frame_done_o <= vs_o && !in_frame;

      if (load_shadow) begin
        sh_width   <= reg_width;
        sh_height  <= reg_height;
        sh_de_gap  <= reg_de_gap;
        sh_hblank  <= reg_hblank;
        sh_vblank  <= reg_vblank;
        sh_pattern <= reg_pattern;
      end

      case (state)
        IDLE: begin
          if (start_ok) begin
            x     <= '0;
            y     <= '0;
            tmr   <= '0;
            state <= LINE;
          end
        end
        LINE: begin
          if (tmr == '0) begin
            de_o <= 1'b1;
            do_o <= pixel;
            if (x == sh_width - CNT_ONE) begin
              if (y == sh_height - CNT_ONE) begin
                tmr   <= vblank_load;
                state <= VBLANK;
              end else begin
                tmr   <= hblank_load;
                state <= HBLANK;
              end
            end else begin
              x   <= x + CNT_ONE;
              tmr <= gap_load;
            end
          end else begin
            tmr <= tmr - CNT_ONE;
          end
        end
        HBLANK: begin
          if (tmr == '0) begin
            x     <= '0;
            y     <= y + CNT_ONE;
            state <= LINE;
          end else begin
            tmr <= tmr - CNT_ONE;
          end
        end
        VBLANK: begin
          if (tmr == '0) begin
            x     <= '0;
            y     <= '0;
            state <= start_ok ? LINE : IDLE;
          end else begin
            tmr <= tmr - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_src.sv
`default_nettype none
// tb_video_pattern_src: randomized and directed frames checked cycle-by-cycle against a frame-level model.
// Revision 1.0
module tb_video_pattern_src;

  localparam int PW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          reg_en;
  logic [CW-1:0] reg_width;
  logic [CW-1:0] reg_height;
  logic [3:0]    reg_de_gap;
  logic [CW-1:0] reg_hblank;
  logic [CW-1:0] reg_vblank;
  logic [1:0]    reg_pattern;
  logic [PW-1:0] do_o;
  logic          de_o;
  logic          hs_o;
  logic          vs_o;
  logic          busy_o;
  logic          frame_done_o;

  always #5 clk = ~clk;

  video_pattern_src #(
    .PIXEL_WIDTH (PW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .reg_en       (reg_en),
    .reg_width    (reg_width),
    .reg_height   (reg_height),
    .reg_de_gap   (reg_de_gap),
    .reg_hblank   (reg_hblank),
    .reg_vblank   (reg_vblank),
    .reg_pattern  (reg_pattern),
    .do_o         (do_o),
    .de_o         (de_o),
    .hs_o         (hs_o),
    .vs_o         (vs_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  typedef struct {
    int de;
    int dat;
    int hs;
    int vs;
    int fd;
    int busy;
    int x;
    int y;
  } rec_t;

  rec_t exp_q[$];
  int   last_do;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, act, exp);
    end
  endtask

  function automatic int pix(input int x, input int y, input int pat);
    int m;
    m = 1 << PW;
    case (pat)
      0:       return x % m;
      1:       return y % m;
      2:       return (x + y) % m;
      default: return (((x / 8) + (y / 8)) % 2 == 1) ? m - 1 : 0;
    endcase
  endfunction

  function automatic void push(input int de, input int dat, input int hs, input int vs,
                               input int fd, input int busy, input int x, input int y);
    rec_t r;
    r = '{de, dat, hs, vs, fd, busy, x, y};
    exp_q.push_back(r);
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) push(0, last_do, 1, 0, 0, 0, -1, -1);
  endfunction

  // One frame of output as seen on the wire: pixels, gaps, line blanking, then frame blanking.
  function automatic void push_frame(input int w, input int h, input int gap,
                                     input int hb, input int vb, input int pat);
    int hbe;
    int vbe;
    hbe = (hb == 0) ? 1 : hb;
    vbe = (vb == 0) ? 1 : vb;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        last_do = pix(xx, yy, pat);
        push(1, last_do, 0, 1, 0, 1, xx, yy);
        if (xx < w - 1)
          for (int g = 0; g < gap; g++) push(0, last_do, 0, 1, 0, 1, -1, -1);
      end
      if (yy < h - 1)
        for (int k = 0; k < hbe; k++) push(0, last_do, 1, 1, 0, 1, -1, -1);
      else
        for (int k = 0; k < vbe; k++) push(0, last_do, 1, 0, int'(k == 0), 1, -1, -1);
    end
  endfunction

  task automatic set_cfg(input int w, input int h, input int gap,
                         input int hb, input int vb, input int pat);
    reg_width   = CW'(w);
    reg_height  = CW'(h);
    reg_de_gap  = 4'(gap);
    reg_hblank  = CW'(hb);
    reg_vblank  = CW'(vb);
    reg_pattern = 2'(pat);
  endtask

  // Compares n samples; at sample dis_idx drops reg_en and scrambles the geometry registers.
  task automatic run_trace(input int n, input int dis_idx);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("de",         int'(de_o),         exp_q[i].de);
      check("do",         int'(do_o),         exp_q[i].dat);
      check("hs",         int'(hs_o),         exp_q[i].hs);
      check("vs",         int'(vs_o),         exp_q[i].vs);
      check("frame_done", int'(frame_done_o), exp_q[i].fd);
      check("busy",       int'(busy_o),       exp_q[i].busy);
      if (i == dis_idx) begin
        reg_en = 1'b0;
        set_cfg(int'($urandom_range(0, 20)), int'($urandom_range(0, 5)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
      end
    end
  endtask

  task automatic scenario(input int w, input int h, input int gap, input int hb,
                          input int vb, input int pat, input int nf);
    int s_last;
    int e;
    int dis;
    exp_q.delete();
    push_idle(1);
    s_last = 1;
    for (int f = 0; f < nf; f++) begin
      s_last = exp_q.size();
      push_frame(w, h, gap, hb, vb, pat);
    end
    e = exp_q.size() - 1;
    push_idle(4);
    dis = int'($urandom_range(e - 1, s_last - 1));
    @(negedge clk);
    set_cfg(w, h, gap, hb, vb, pat);
    reg_en = 1'b1;
    run_trace(exp_q.size(), dis);
  endtask

  task automatic reset_test();
    int r;
    int e;
    exp_q.delete();
    push_idle(1);
    push_frame(4, 3, 0, 2, 2, 2);
    r = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (r == 0 && exp_q[i].de == 1 && exp_q[i].x == 2 && exp_q[i].y == 1) r = i;
    @(negedge clk);
    set_cfg(4, 3, 0, 2, 2, 2);
    reg_en = 1'b1;
    run_trace(r + 1, -1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_de",   int'(de_o),         0);
    check("rst_do",   int'(do_o),         0);
    check("rst_hs",   int'(hs_o),         1);
    check("rst_vs",   int'(vs_o),         0);
    check("rst_busy", int'(busy_o),       0);
    check("rst_fd",   int'(frame_done_o), 0);
    rst = 1'b0;
    last_do = 0;
    exp_q.delete();
    push_idle(1);
    push_frame(4, 3, 0, 2, 2, 2);
    e = exp_q.size() - 1;
    push_idle(3);
    run_trace(exp_q.size(), e - 1);
  endtask

  task automatic zero_geom_test(input int w, input int h);
    @(negedge clk);
    set_cfg(w, h, 1, 2, 2, 0);
    reg_en = 1'b1;
    exp_q.delete();
    push_idle(10);
    run_trace(10, -1);
    reg_en = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    reg_en  = 1'b0;
    last_do = 0;
    set_cfg(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_de",   int'(de_o),         0);
    check("reset_do",   int'(do_o),         0);
    check("reset_hs",   int'(hs_o),         1);
    check("reset_vs",   int'(vs_o),         0);
    check("reset_busy", int'(busy_o),       0);
    check("reset_fd",   int'(frame_done_o), 0);
    rst = 1'b0;

    scenario(4, 2, 0, 3, 2, 0, 3);
    scenario(3, 3, 1, 1, 1, 1, 2);
    scenario(300, 2, 0, 1, 1, 2, 1);
    reset_test();
    zero_geom_test(0, 3);
    zero_geom_test(5, 0);
    scenario(1, 1, 0, 0, 0, 3, 2);

    for (int n = 0; n < 10; n++)
      scenario(int'($urandom_range(1, 20)), int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
               int'($urandom_range(1, 3)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
